// File: rtl/acc_pkg.sv
// Shared datapath definitions: default machine word width and word type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Imported by the accumulator and the other datapath blocks so that every
// block agrees on one definition of the machine word.
package acc_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/acc.sv
// Accumulator register with zero/negative status flags.
// Latency: 1 cycle from WrAcc/SelA at a rising edge to AccOut; flags are combinational on AccOut.
// Backpressure: none; a write is accepted on every edge where WrAcc is high.
//
// Ports:
//   Clock    - system clock, rising-edge active
//   ResetN   - asynchronous active-low reset, loads RESET_VALUE
//   SelA     - value to load (selected A operand or ALU result)
//   WrAcc    - load enable, sampled at the rising edge
//   AccOut   - registered accumulator contents
//   AccZero  - high when AccOut is zero
//   AccNeg   - two's-complement sign of AccOut
module acc
  import acc_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] SelA,
  input  logic             WrAcc,
  output logic [WIDTH-1:0] AccOut,
  output logic             AccZero,
  output logic             AccNeg
);

  logic [WIDTH-1:0] accReg;

  // Reset is checked first, so it wins over a simultaneous write. When WrAcc
  // is low the register recirculates its own value (mux-style enable).
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      accReg <= RESET_VALUE;
    end else if (WrAcc) begin
      accReg <= SelA;
    end
  end

  assign AccOut  = accReg;
  assign AccZero = (accReg == '0);
  assign AccNeg  = accReg[WIDTH-1];

endmodule

// File: tb/tb_acc.sv
// Self-checking bench for the accumulator: scoreboard queue fed by stimulus,
// drained by an independent monitor after each rising edge.
module tb_acc;
  import acc_pkg::*;

  localparam word_t RST_VAL = '0;

  logic  Clock = 1'b0;
  logic  ResetN;
  word_t SelA;
  logic  WrAcc;
  word_t AccOut;
  logic  AccZero;
  logic  AccNeg;

  bit    clkEn   = 1'b0;
  bit    started = 1'b0;
  bit    inReset;
  word_t modelAcc;
  word_t lastExp;
  word_t expQ[$];

  int checks = 0;
  int errors = 0;

  acc #(
    .WIDTH      (WORD_W),
    .RESET_VALUE(RST_VAL)
  ) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .SelA   (SelA),
    .WrAcc  (WrAcc),
    .AccOut (AccOut),
    .AccZero(AccZero),
    .AccNeg (AccNeg)
  );

  // 20 ns period, held low until the reset-without-clock check is done.
  always begin
    #10;
    if (clkEn) Clock = ~Clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Expected flags come from the arithmetic meaning of the word, not bit picks.
  task automatic chkAll(input string nm, input word_t e);
    chk({nm, ".AccOut"},  32'(AccOut),  32'(e));
    chk({nm, ".AccZero"}, 32'(AccZero), 32'(e == 0));
    chk({nm, ".AccNeg"},  32'(AccNeg),  32'($signed(e) < 0));
  endtask

  // Monitor: one expected word per rising edge, compared just after the edge.
  always @(posedge Clock) begin
    #1;
    if (expQ.size() > 0) begin
      lastExp = expQ.pop_front();
      chkAll("edge", lastExp);
    end
  end

  // Mid-cycle: the register must still hold the value from the last edge.
  always @(negedge Clock) begin
    if (started) chkAll("hold", lastExp);
  end

  // One clock cycle of stimulus. Inputs change 2 ns after the edge; an optional
  // mid-cycle SelA change and/or reset assertion happen 12 ns after the edge.
  // The model value for the coming edge uses whatever is applied at that edge.
  task automatic cycle(input bit wr, input word_t sel, input bit chgMid, input word_t midSel,
                       input bit rstMid, input bit rstRel);
    @(posedge Clock);
    #2;
    if (rstRel) begin
      ResetN  = 1'b1;
      inReset = 1'b0;
    end
    WrAcc = wr;
    SelA  = sel;
    #10;
    if (chgMid) begin
      SelA = midSel;
      #1;
      chkAll("midSel", modelAcc);
    end
    if (rstMid) begin
      ResetN   = 1'b0;
      inReset  = 1'b1;
      modelAcc = RST_VAL;
      #1;
      chkAll("asyncRst", RST_VAL);
    end
    if (!inReset && WrAcc) modelAcc = SelA;
    expQ.push_back(modelAcc);
  endtask

  function automatic word_t pickVal();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h7FFF;
      default: return word_t'($urandom);
    endcase
  endfunction

  initial begin
    // Reset asserted with no clock running: outputs must follow immediately.
    ResetN   = 1'b0;
    WrAcc    = 1'b0;
    SelA     = '0;
    inReset  = 1'b1;
    modelAcc = RST_VAL;
    lastExp  = RST_VAL;
    #1;
    chkAll("resetNoClk", RST_VAL);
    #1;
    clkEn   = 1'b1;
    started = 1'b1;

    // Release reset; SelA=247 with WrAcc low for 5 edges: no change.
    cycle(1'b0, 16'd247, 1'b0, '0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 16'd247, 1'b0, '0, 1'b0, 1'b0);
    // Load 247.
    cycle(1'b1, 16'd247, 1'b0, '0, 1'b0, 1'b0);
    // SelA changes to 2222 mid-cycle: holds 247 until the edge, then 2222.
    cycle(1'b1, 16'd247, 1'b1, 16'd2222, 1'b0, 1'b0);
    // Write disabled, SelA moves to 0x8000: hold 2222.
    cycle(1'b0, 16'h8000, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 16'h8000, 1'b0, '0, 1'b0, 1'b0);
    // One-edge write pulse: 0x8000, negative.
    cycle(1'b1, 16'h8000, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 16'h1234, 1'b0, '0, 1'b0, 1'b0);
    // Back-to-back writes.
    cycle(1'b1, 16'h0001, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 16'h7FFF, 1'b0, '0, 1'b0, 1'b0);
    // Reset mid-cycle with WrAcc high; stays at reset value through edges.
    cycle(1'b1, 16'h4321, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'd999, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 16'd999, 1'b0, '0, 1'b0, 1'b0);
    // Release: the first write edge is a normal load.
    cycle(1'b1, 16'd555, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 16'd0, 1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic with occasional mid-cycle SelA changes and resets.
    for (int i = 0; i < 300; i++) begin
      bit    wr, chg, rMid, rRel;
      word_t s, m;
      wr   = ($urandom_range(0, 1) == 1);
      s    = pickVal();
      m    = pickVal();
      chg  = ($urandom_range(0, 3) == 0);
      rRel = inReset && ($urandom_range(0, 1) == 1);
      rMid = !inReset && ($urandom_range(0, 29) == 0);
      cycle(wr, s, chg, m, rMid, rRel);
    end
    if (inReset) cycle(1'b1, 16'hBEEF, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, '0, 1'b0, 1'b0);

    // Bounded drain of the scoreboard.
    for (int n = 0; n < 5 && expQ.size() > 0; n++) @(posedge Clock);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc.md
ACC -- requirements
Module: acc

Interface
REQ-001 Parameter WIDTH, default 16: data width of the accumulator and its data ports.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into the accumulator on reset, WIDTH bits.
REQ-003 Clock  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 SelA  input  WIDTH  data to be loaded into the accumulator, normally the selected A-operand or ALU result.
REQ-006 WrAcc  input  1  write enable; when high, the accumulator loads SelA.
REQ-007 AccOut  output  WIDTH  current accumulator contents, driven directly from the register.
REQ-008 AccZero  output  1  high when AccOut equals 0.
REQ-009 AccNeg  output  1  equals AccOut[WIDTH-1], the two's-complement sign.

Function
REQ-010 On a rising Clock edge with ResetN high and WrAcc high, the accumulator SHALL load SelA, and AccOut SHALL show the new value after that edge (1-cycle latency).
REQ-011 On a rising Clock edge with ResetN high and WrAcc low, the accumulator SHALL hold its value, whatever SelA is doing.
REQ-012 SelA and WrAcc SHALL be sampled only at the rising edge; changes between edges SHALL NOT affect AccOut.
REQ-013 The load SHALL be a full-width copy: no arithmetic, truncation or sign extension.
REQ-014 AccZero and AccNeg SHALL be combinational functions of the registered AccOut only, with no extra latency and no dependence on SelA.
REQ-015 If WrAcc stays high on consecutive edges, each edge SHALL load the SelA value present at that edge (back-to-back writes).
REQ-016 X/Z on SelA SHALL propagate only when WrAcc is high at an edge.

Reset
REQ-017 ResetN low SHALL immediately force AccOut to RESET_VALUE, without waiting for a Clock edge.
REQ-018 While ResetN is low, AccZero SHALL equal (RESET_VALUE == 0) and AccNeg SHALL equal RESET_VALUE[WIDTH-1].
REQ-019 While ResetN is low, WrAcc SHALL be ignored, and reset SHALL take priority over any simultaneous write.
REQ-020 After ResetN deasserts, the first rising edge with WrAcc high SHALL perform a normal load.

Structure
REQ-021 WIDTH's default value and the word type SHALL live in the shared CPU package, so the accumulator and other datapath blocks use the same definition.
REQ-022 The block SHALL be a single module with one register process and continuous assignments for the flags; no sub-module is needed.
REQ-023 The block SHALL contain no latches and no internal clock gating; the enable SHALL be implemented as a mux into the register or a flop clock-enable.

Verification (20 ns clock period)
REQ-024 Assert ResetN low with SelA=0 and WrAcc=0 -> AccOut=0, AccZero=1, AccNeg=0, with no Clock edge required.
REQ-025 Release reset, set SelA=247 with WrAcc=0 for 5 edges -> AccOut stays 0.
REQ-026 Set WrAcc=1 with SelA=247 -> after the next rising edge, AccOut=247 and AccZero=0.
REQ-027 With WrAcc=1, change SelA to 2222 mid-cycle -> AccOut stays 247 until the next rising edge, then becomes 2222.
REQ-028 Set WrAcc=0, then SelA=16'h8000 -> AccOut holds 2222; then pulse WrAcc for one edge -> AccOut=16'h8000 and AccNeg=1.
REQ-029 Assert ResetN low between edges with WrAcc=1 -> AccOut=0 at once; it stays 0 through edges until release.
